// File: rtl/clock_edit_controller.sv
// Front-panel controller: conditions four raw active-low keys into debounced command
// pulses and runs the VIEW/EDIT state machine that drives the time counters and display.
module clock_edit_controller #(
    parameter int DEBOUNCE      = 4,
    parameter int LONG_CYCLES   = 40,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 10,
    parameter int TIMEOUT       = 500,
    parameter int BLINK_HALF    = 25
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] KEY,
    output logic       editMode,
    output logic [2:0] editCur,
    output logic [1:0] disMode,
    output logic       incPulse,
    output logic       decPulse,
    output logic       clrPulse,
    output logic       blink
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    localparam logic [DW-1:0] DEB_ZERO   = DW'(0);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] HOLD_ZERO  = LW'(0);
    localparam logic [LW-1:0] HOLD_ONE   = LW'(1);
    localparam logic [LW-1:0] HOLD_LAST  = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_MAX   = LW'(LONG_CYCLES);
    localparam logic [RW-1:0] REP_ZERO   = RW'(0);
    localparam logic [RW-1:0] REP_ONE    = RW'(1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [TW-1:0] IDLE_ZERO  = TW'(0);
    localparam logic [TW-1:0] IDLE_ONE   = TW'(1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLK_ZERO   = BW'(0);
    localparam logic [BW-1:0] BLK_ONE    = BW'(1);
    localparam logic [BW-1:0] BLK_LAST   = BW'(BLINK_HALF - 1);

    typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_UP = 2'd1, OWN_DOWN = 2'd2, OWN_BLOCK = 2'd3} own_t;

    logic [3:0]    sync1_r, sync2_r, armed_r, deb_r, debDly_r;
    logic [DW-1:0] debCnt_r [4];
    logic [3:0]    keyPress_s, keyRelease_s, keyHeld_s;

    state_t        state_r;
    own_t          own_r, ownNext_s;
    logic          editMode_r, incPulse_r, decPulse_r, clrPulse_r, blink_r;
    logic [2:0]    editCur_r;
    logic [1:0]    disMode_r;
    logic [LW-1:0] holdCnt_r, holdNext_s;
    logic [RW-1:0] repCnt_r, repNext_s;
    logic [TW-1:0] idleCnt_r, idleNext_s;
    logic [BW-1:0] blinkCnt_r, blinkCntNext_s;
    logic          blinkNext_s, incFire_s, decFire_s;
    logic          keyAct_s, longPress_s, shortPress_s, timeout_s;

    // Synchronize and debounce; a key only arms once it is seen released after reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_r  <= 4'b0000;
            sync2_r  <= 4'b0000;
            armed_r  <= 4'b0000;
            deb_r    <= 4'b1111;
            debDly_r <= 4'b1111;
            for (int i = 0; i < 4; i++) debCnt_r[i] <= DEB_ZERO;
        end else begin
            sync1_r  <= KEY;
            sync2_r  <= sync1_r;
            debDly_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                if (!armed_r[i]) begin
                    armed_r[i]  <= sync2_r[i];
                    debCnt_r[i] <= DEB_ZERO;
                end else if (sync2_r[i] != deb_r[i]) begin
                    if (debCnt_r[i] == DEB_LAST) begin
                        deb_r[i]    <= sync2_r[i];
                        debCnt_r[i] <= DEB_ZERO;
                    end else begin
                        debCnt_r[i] <= debCnt_r[i] + DEB_ONE;
                    end
                end else begin
                    debCnt_r[i] <= DEB_ZERO;
                end
            end
        end
    end

    assign keyPress_s   = debDly_r & ~deb_r;
    assign keyRelease_s = ~debDly_r & deb_r;
    assign keyHeld_s    = ~deb_r;

    // Mode-key hold length, idle timer and timeout/long/short decisions
    always_comb begin
        keyAct_s     = (|keyPress_s[3:1]) || (|keyRelease_s[3:1]);
        longPress_s  = keyHeld_s[3] && (holdCnt_r == HOLD_LAST);
        shortPress_s = keyRelease_s[3] && (holdCnt_r != HOLD_MAX);
        timeout_s    = (idleCnt_r == IDLE_LAST) && !keyAct_s;
        if (!keyHeld_s[3]) begin
            holdNext_s = HOLD_ZERO;
        end else if (holdCnt_r != HOLD_MAX) begin
            holdNext_s = holdCnt_r + HOLD_ONE;
        end else begin
            holdNext_s = holdCnt_r;
        end
        if (keyAct_s) begin
            idleNext_s = IDLE_ZERO;
        end else if (idleCnt_r != IDLE_LAST) begin
            idleNext_s = idleCnt_r + IDLE_ONE;
        end else begin
            idleNext_s = idleCnt_r;
        end
    end

    // Up/down ownership: first key wins, simultaneous presses block both until released
    always_comb begin
        incFire_s = 1'b0;
        decFire_s = 1'b0;
        ownNext_s = own_r;
        repNext_s = repCnt_r;
        if (state_r == VIEW) begin
            repNext_s = REP_ZERO;
            if (deb_r[1] && deb_r[2]) ownNext_s = OWN_NONE;
            else ownNext_s = OWN_BLOCK;
        end else begin
            case (own_r)
                OWN_NONE: begin
                    repNext_s = REP_ZERO;
                    if (keyPress_s[1] && keyPress_s[2]) begin
                        ownNext_s = OWN_BLOCK;
                    end else if (keyPress_s[1] && deb_r[2]) begin
                        ownNext_s = OWN_UP;
                        incFire_s = 1'b1;
                    end else if (keyPress_s[2] && deb_r[1]) begin
                        ownNext_s = OWN_DOWN;
                        decFire_s = 1'b1;
                    end else begin
                        ownNext_s = OWN_NONE;
                    end
                end
                OWN_UP: begin
                    if (deb_r[1]) begin
                        ownNext_s = OWN_NONE;
                        repNext_s = REP_ZERO;
                    end else if (repCnt_r == REP_LAST) begin
                        incFire_s = 1'b1;
                        repNext_s = REP_RELOAD;
                    end else begin
                        repNext_s = repCnt_r + REP_ONE;
                    end
                end
                OWN_DOWN: begin
                    if (deb_r[2]) begin
                        ownNext_s = OWN_NONE;
                        repNext_s = REP_ZERO;
                    end else if (repCnt_r == REP_LAST) begin
                        decFire_s = 1'b1;
                        repNext_s = REP_RELOAD;
                    end else begin
                        repNext_s = repCnt_r + REP_ONE;
                    end
                end
                OWN_BLOCK: begin
                    if (deb_r[1] && deb_r[2]) ownNext_s = OWN_NONE;
                    else ownNext_s = OWN_BLOCK;
                end
                default: ownNext_s = OWN_NONE;
            endcase
        end
    end

    // Blink phase in EDIT; an inc/dec command re-shows the digit and restarts the phase
    always_comb begin
        if (incFire_s || decFire_s) begin
            blinkNext_s    = 1'b1;
            blinkCntNext_s = BLK_ZERO;
        end else if (blinkCnt_r == BLK_LAST) begin
            blinkNext_s    = ~blink_r;
            blinkCntNext_s = BLK_ZERO;
        end else begin
            blinkNext_s    = blink_r;
            blinkCntNext_s = blinkCnt_r + BLK_ONE;
        end
    end

    // VIEW/EDIT state machine with registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= VIEW;
            own_r      <= OWN_NONE;
            editMode_r <= 1'b0;
            editCur_r  <= 3'd5;
            disMode_r  <= 2'd0;
            incPulse_r <= 1'b0;
            decPulse_r <= 1'b0;
            clrPulse_r <= 1'b0;
            blink_r    <= 1'b1;
            holdCnt_r  <= HOLD_ZERO;
            repCnt_r   <= REP_ZERO;
            idleCnt_r  <= IDLE_ZERO;
            blinkCnt_r <= BLK_ZERO;
        end else begin
            incPulse_r <= incFire_s;
            decPulse_r <= decFire_s;
            clrPulse_r <= keyPress_s[0];
            own_r      <= ownNext_s;
            repCnt_r   <= repNext_s;
            holdCnt_r  <= holdNext_s;
            case (state_r)
                VIEW: begin
                    idleCnt_r  <= IDLE_ZERO;
                    blink_r    <= 1'b1;
                    blinkCnt_r <= BLK_ZERO;
                    if (longPress_s) begin
                        state_r    <= EDIT;
                        editMode_r <= 1'b1;
                        editCur_r  <= 3'd5;
                        disMode_r  <= 2'd0;
                    end else if (shortPress_s) begin
                        disMode_r <= (disMode_r == 2'd2) ? 2'd0 : disMode_r + 2'd1;
                    end
                end
                EDIT: begin
                    idleCnt_r  <= idleNext_s;
                    blink_r    <= blinkNext_s;
                    blinkCnt_r <= blinkCntNext_s;
                    if (longPress_s || timeout_s) begin
                        state_r    <= VIEW;
                        editMode_r <= 1'b0;
                        blink_r    <= 1'b1;
                        blinkCnt_r <= BLK_ZERO;
                        idleCnt_r  <= IDLE_ZERO;
                    end else if (shortPress_s) begin
                        editCur_r <= (editCur_r == 3'd0) ? 3'd5 : editCur_r - 3'd1;
                    end
                end
                default: begin
                    state_r    <= VIEW;
                    editMode_r <= 1'b0;
                    blink_r    <= 1'b1;
                end
            endcase
        end
    end

    assign editMode = editMode_r;
    assign editCur  = editCur_r;
    assign disMode  = disMode_r;
    assign incPulse = incPulse_r;
    assign decPulse = decPulse_r;
    assign clrPulse = clrPulse_r;
    assign blink    = blink_r;
endmodule

// File: tb/tb_clock_edit_controller.sv
// Directed bench for clock_edit_controller at default parameters; expected cycle
// offsets count posedges after the raw KEY change (2 sync + 4 debounce + 1).
module tb_clock_edit_controller;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] KEY;
    logic       editMode, incPulse, decPulse, clrPulse, blink;
    logic [2:0] editCur;
    logic [1:0] disMode;
    int total = 0;
    int bad = 0;
    int nInc, nDec, nClr, firstClr;
    int decAt [8];

    always #5 Clk = ~Clk;

    clock_edit_controller dut (
        .Clk(Clk), .Rst(Rst), .KEY(KEY),
        .editMode(editMode), .editCur(editCur), .disMode(disMode),
        .incPulse(incPulse), .decPulse(decPulse), .clrPulse(clrPulse), .blink(blink)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step n cycles counting pulses; optionally change KEY at chgAt and release all at relAt
    task automatic watch(input int n, input int chgAt, input logic [3:0] chgKey, input int relAt,
                         output int incs, output int decs, output int clrs, output int fClr);
        incs = 0; decs = 0; clrs = 0; fClr = 0;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (incPulse) incs++;
            if (decPulse) decs++;
            if (clrPulse) begin
                if (clrs == 0) fClr = i;
                clrs++;
            end
            if (i == chgAt) KEY = chgKey;
            if (i == relAt) KEY = 4'hF;
        end
    endtask

    initial begin
        KEY = 4'hF;
        Rst = 1'b1;
        tick(3);
        chk("rst_editMode", editMode, 0);
        chk("rst_editCur", editCur, 5);
        chk("rst_disMode", disMode, 0);
        chk("rst_inc", incPulse, 0);
        chk("rst_dec", decPulse, 0);
        chk("rst_clr", clrPulse, 0);
        chk("rst_blink", blink, 1);
        Rst = 1'b0;
        tick(5);

        // short mode press in VIEW: page advances 7 cycles after release
        KEY = 4'b0111; tick(10);
        KEY = 4'hF; tick(6);
        chk("short_dis_early", disMode, 0);
        tick(1);
        chk("short_dis", disMode, 1);
        tick(10);

        // long press: EDIT entered at 2+4+40 = 46
        KEY = 4'b0111; tick(45);
        chk("long_early", editMode, 0);
        tick(1);
        chk("long_editMode", editMode, 1);
        chk("long_editCur", editCur, 5);
        chk("long_disMode", disMode, 0);
        chk("long_blink_entry", blink, 1);
        tick(24);
        chk("blink_hold", blink, 1);
        tick(1);
        chk("blink_toggle", blink, 0);
        tick(10);
        KEY = 4'hF; tick(15);
        chk("long_release_mode", editMode, 1);
        chk("long_release_cur", editCur, 5);

        // cursor walks 4,3,2,1,0,5
        for (int i = 0; i < 6; i++) begin
            KEY = 4'b0111; tick(10);
            KEY = 4'hF; tick(10);
            chk("cursor", editCur, (i < 5) ? 4 - i : 5);
        end

        // single up tap
        KEY = 4'b1101; tick(6);
        chk("inc_early", incPulse, 0);
        tick(1);
        chk("inc_pulse", incPulse, 1);
        chk("inc_no_dec", decPulse, 0);
        chk("inc_blink", blink, 1);
        tick(1);
        chk("inc_width", incPulse, 0);
        tick(2);
        KEY = 4'hF;
        watch(25, 0, 4'hF, 0, nInc, nDec, nClr, firstClr);
        chk("inc_single", nInc, 0);

        // held down: pulses at 7, 37, 47, 57, 67
        KEY = 4'b1011;
        nDec = 0; nInc = 0;
        for (int i = 1; i <= 90; i++) begin
            tick(1);
            if (decPulse) begin
                if (nDec < 8) decAt[nDec] = i;
                nDec++;
            end
            if (incPulse) nInc++;
            if (i == 64) KEY = 4'hF;
        end
        chk("rep_count", nDec, 5);
        chk("rep_no_inc", nInc, 0);
        for (int k = 0; k < 5; k++) chk("rep_at", decAt[k], (k == 0) ? 7 : 27 + 10 * k);

        // same-cycle up+down: nothing fires
        KEY = 4'b1001;
        watch(40, 0, 4'hF, 15, nInc, nDec, nClr, firstClr);
        chk("both_inc", nInc, 0);
        chk("both_dec", nDec, 0);

        // down pressed while up held: down ignored
        KEY = 4'b1101;
        watch(45, 15, 4'b1001, 20, nInc, nDec, nClr, firstClr);
        chk("later_inc", nInc, 1);
        chk("later_dec", nDec, 0);

        // 3-cycle clear glitch, then a real clear press
        KEY = 4'b1110; tick(3);
        KEY = 4'hF;
        watch(20, 0, 4'hF, 0, nInc, nDec, nClr, firstClr);
        chk("glitch_clr", nClr, 0);
        KEY = 4'b1110;
        watch(30, 0, 4'hF, 10, nInc, nDec, nClr, firstClr);
        chk("clr_count", nClr, 1);
        chk("clr_latency", firstClr, 7);
        chk("clr_keeps_edit", editMode, 1);

        // timeout: 500 idle cycles after the last release event (edge 7)
        KEY = 4'b1101; tick(10);
        KEY = 4'hF; tick(500);
        chk("timeout_early", editMode, 1);
        tick(10);
        chk("timeout_mode", editMode, 0);
        chk("timeout_blink", blink, 1);
        chk("timeout_cur", editCur, 5);
        chk("timeout_dis", disMode, 0);

        // VIEW ignores up
        KEY = 4'b1101;
        watch(30, 0, 4'hF, 10, nInc, nDec, nClr, firstClr);
        chk("view_no_inc", nInc, 0);

        // reset while clear is held: no event until release and re-press
        KEY = 4'b1110; tick(10);
        Rst = 1'b1; tick(3);
        Rst = 1'b0;
        watch(30, 0, 4'hF, 0, nInc, nDec, nClr, firstClr);
        chk("rst_hold_clr", nClr, 0);
        KEY = 4'hF;
        watch(20, 0, 4'hF, 0, nInc, nDec, nClr, firstClr);
        chk("rst_release_clr", nClr, 0);
        KEY = 4'b1110;
        watch(25, 0, 4'hF, 10, nInc, nDec, nClr, firstClr);
        chk("rst_repress_clr", nClr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
